// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared widths and operand-fetch state encoding
package rv32i_pkg;

    localparam int XLEN           = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_FILE_SIZE  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        OUT   = 2'd2
    } opf_state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending-write busy vector
module regfile_scoreboard
    import rv32i_pkg::*;
#(
    parameter int N  = REG_FILE_SIZE,
    parameter int AW = REG_ADDR_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          set_en,
    input  logic [AW-1:0] set_idx,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_idx,
    output logic [N-1:0]  busy_vec
);

    logic [N-1:0] busy_q;
    logic [N-1:0] busy_d;

    // Clear first so a same-cycle set from a younger instruction survives.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_idx] = 1'b0;
        if (set_en) busy_d[set_idx] = 1'b1;
        if (flush)  busy_d = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy_q <= '0;
        else      busy_q <= busy_d;
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - regfile read, RAW stall, writeback forwarding, operand handoff
module operand_fetch
    import rv32i_pkg::*;
#(
    parameter int XW = XLEN,
    parameter int AW = REG_ADDR_WIDTH,
    parameter int NR = REG_FILE_SIZE
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          id_valid,
    output logic          id_ready,
    input  logic [AW-1:0] id_rs1,
    input  logic [AW-1:0] id_rs2,
    input  logic [AW-1:0] id_rd,
    input  logic          id_rd_we,
    output logic [AW-1:0] rf_r1_addr,
    output logic [AW-1:0] rf_r2_addr,
    input  logic [XW-1:0] rf_r1_data,
    input  logic [XW-1:0] rf_r2_data,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [XW-1:0] wb_data,
    output logic          ex_valid,
    input  logic          ex_ready,
    output logic [XW-1:0] ex_rs1_data,
    output logic [XW-1:0] ex_rs2_data,
    output logic [AW-1:0] ex_rd,
    output logic          ex_rd_we,
    output logic [NR-1:0] busy_vec
);

    opf_state_t    state_q, state_d;
    logic [AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic          rd_we_q, rd_we_d;
    logic          ok1_q, ok1_d, ok2_q, ok2_d;
    logic          ex_valid_q, ex_valid_d;
    logic [XW-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
    logic [AW-1:0] ex_rd_q, ex_rd_d;
    logic          ex_rd_we_q, ex_rd_we_d;
    logic          sb_set;

    always_comb begin
        state_d    = state_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        rd_we_d    = rd_we_q;
        ok1_d      = ok1_q;
        ok2_d      = ok2_q;
        ex_valid_d = ex_valid_q;
        ex_rs1_d   = ex_rs1_q;
        ex_rs2_d   = ex_rs2_q;
        ex_rd_d    = ex_rd_q;
        ex_rd_we_d = ex_rd_we_q;
        sb_set     = 1'b0;
        case (state_q)
            IDLE: begin
                if (id_valid) begin
                    rs1_d   = id_rs1;
                    rs2_d   = id_rs2;
                    rd_d    = id_rd;
                    rd_we_d = id_rd_we;
                    ok1_d   = 1'b0;
                    ok2_d   = 1'b0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // x0 must read as zero here: the regfile storage does not hardwire it.
                if (!ok1_q) begin
                    if (rs1_q == '0) begin
                        ex_rs1_d = '0;          ok1_d = 1'b1;
                    end else if (wb_en && wb_addr == rs1_q) begin
                        ex_rs1_d = wb_data;     ok1_d = 1'b1;
                    end else if (!busy_vec[rs1_q]) begin
                        ex_rs1_d = rf_r1_data;  ok1_d = 1'b1;
                    end
                end
                if (!ok2_q) begin
                    if (rs2_q == '0) begin
                        ex_rs2_d = '0;          ok2_d = 1'b1;
                    end else if (wb_en && wb_addr == rs2_q) begin
                        ex_rs2_d = wb_data;     ok2_d = 1'b1;
                    end else if (!busy_vec[rs2_q]) begin
                        ex_rs2_d = rf_r2_data;  ok2_d = 1'b1;
                    end
                end
                if (ok1_d && ok2_d) begin
                    state_d    = OUT;
                    ex_valid_d = 1'b1;
                    ex_rd_d    = rd_q;
                    ex_rd_we_d = rd_we_q;
                    sb_set     = rd_we_q;
                end
            end
            OUT: begin
                if (ex_ready) begin
                    state_d    = IDLE;
                    ex_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d    = IDLE;
            ex_valid_d = 1'b0;
            sb_set     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            rd_we_q    <= 1'b0;
            ok1_q      <= 1'b0;
            ok2_q      <= 1'b0;
            ex_valid_q <= 1'b0;
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
            ex_rd_q    <= '0;
            ex_rd_we_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            rd_we_q    <= rd_we_d;
            ok1_q      <= ok1_d;
            ok2_q      <= ok2_d;
            ex_valid_q <= ex_valid_d;
            ex_rs1_q   <= ex_rs1_d;
            ex_rs2_q   <= ex_rs2_d;
            ex_rd_q    <= ex_rd_d;
            ex_rd_we_q <= ex_rd_we_d;
        end
    end

    regfile_scoreboard #(.N(NR), .AW(AW)) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .set_en   (sb_set),
        .set_idx  (rd_q),
        .clr_en   (wb_en),
        .clr_idx  (wb_addr),
        .busy_vec (busy_vec)
    );

    assign id_ready    = (state_q == IDLE);
    assign rf_r1_addr  = rs1_q;
    assign rf_r2_addr  = rs2_q;
    assign ex_valid    = ex_valid_q;
    assign ex_rs1_data = ex_rs1_q;
    assign ex_rs2_data = ex_rs2_q;
    assign ex_rd       = ex_rd_q;
    assign ex_rd_we    = ex_rd_we_q;

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - directed self-checking bench for operand_fetch
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_rd_we;
    logic [4:0]  rf_r1_addr, rf_r2_addr;
    logic [31:0] rf_r1_data, rf_r2_data;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_rs1_data, ex_rs2_data;
    logic [4:0]  ex_rd;
    logic        ex_rd_we;
    logic [31:0] busy_vec;

    logic [31:0] rf [32];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign rf_r1_data = rf[rf_r1_addr];
    assign rf_r2_data = rf[rf_r2_addr];

    operand_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .id_rd_we    (id_rd_we),
        .rf_r1_addr  (rf_r1_addr),
        .rf_r2_addr  (rf_r2_addr),
        .rf_r1_data  (rf_r1_data),
        .rf_r2_data  (rf_r2_data),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_rs1_data (ex_rs1_data),
        .ex_rs2_data (ex_rs2_data),
        .ex_rd       (ex_rd),
        .ex_rd_we    (ex_rd_we),
        .busy_vec    (busy_vec)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic we);
        id_valid = 1'b1;
        id_rs1   = rs1;
        id_rs2   = rs2;
        id_rd    = rd;
        id_rd_we = we;
        step();
        id_valid = 1'b0;
    endtask

    task automatic wb_cycle(input logic [4:0] addr, input logic [31:0] data);
        wb_en   = 1'b1;
        wb_addr = addr;
        wb_data = data;
        step();
        rf[addr] = data;
        wb_en   = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rst = 1'b0; flush = 1'b0; id_valid = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_rd_we = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; ex_ready = 1'b1;

        // Reset
        repeat (3) step();
        check("rst_hold_ex_valid", {31'b0, ex_valid}, 32'd0);
        rst = 1'b1;
        step();
        check("rst_id_ready", {31'b0, id_ready}, 32'd1);
        check("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        check("rst_busy_vec", busy_vec, 32'h0);
        check("rst_rf_addrs", {22'b0, rf_r1_addr, rf_r2_addr}, 32'h0);

        // No hazard
        rf[5] = 32'h1234; rf[6] = 32'hABCD;
        issue(5'd5, 5'd6, 5'd7, 1'b1);
        check("nh_fetch_ex_valid", {31'b0, ex_valid}, 32'd0);
        check("nh_fetch_id_ready", {31'b0, id_ready}, 32'd0);
        check("nh_rf_r1_addr", {27'b0, rf_r1_addr}, 32'd5);
        check("nh_rf_r2_addr", {27'b0, rf_r2_addr}, 32'd6);
        step();
        check("nh_ex_valid", {31'b0, ex_valid}, 32'd1);
        check("nh_rs1", ex_rs1_data, 32'h1234);
        check("nh_rs2", ex_rs2_data, 32'hABCD);
        check("nh_rd", {27'b0, ex_rd}, 32'd7);
        check("nh_rd_we", {31'b0, ex_rd_we}, 32'd1);
        check("nh_busy", busy_vec, 32'h0000_0080);
        step();
        check("nh_back_idle", {31'b0, id_ready}, 32'd1);
        check("nh_ex_valid_drop", {31'b0, ex_valid}, 32'd0);

        // RAW on x7 with forwarding from writeback
        issue(5'd7, 5'd5, 5'd8, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("raw_stall_ex_valid", {31'b0, ex_valid}, 32'd0);
            check("raw_stall_id_ready", {31'b0, id_ready}, 32'd0);
            step();
        end
        wb_cycle(5'd7, 32'h55);
        check("raw_ex_valid", {31'b0, ex_valid}, 32'd1);
        check("raw_rs1_fwd", ex_rs1_data, 32'h55);
        check("raw_rs2", ex_rs2_data, 32'h1234);
        check("raw_busy_clr", busy_vec, 32'h0);
        step();

        // x0 source and x0 destination
        rf[0] = 32'hDEAD_BEEF;
        issue(5'd0, 5'd6, 5'd0, 1'b1);
        step();
        check("x0_ex_valid", {31'b0, ex_valid}, 32'd1);
        check("x0_rs1_zero", ex_rs1_data, 32'h0);
        check("x0_rs2", ex_rs2_data, 32'hABCD);
        check("x0_busy_none", busy_vec, 32'h0);
        step();

        // Backpressure
        ex_ready = 1'b0;
        issue(5'd5, 5'd6, 5'd10, 1'b1);
        step();
        for (int i = 0; i < 5; i++) begin
            check("bp_ex_valid", {31'b0, ex_valid}, 32'd1);
            check("bp_rs1", ex_rs1_data, 32'h1234);
            check("bp_rs2", ex_rs2_data, 32'hABCD);
            check("bp_rd", {27'b0, ex_rd}, 32'd10);
            check("bp_id_ready", {31'b0, id_ready}, 32'd0);
            step();
        end
        check("bp_busy", busy_vec, 32'h0000_0400);
        ex_ready = 1'b1;
        step();
        check("bp_release_idle", {31'b0, id_ready}, 32'd1);
        check("bp_release_ex_valid", {31'b0, ex_valid}, 32'd0);
        wb_cycle(5'd10, 32'h10);
        check("bp_wb_clear", busy_vec, 32'h0);

        // Same-edge set and clear of x9: set must win
        rf[1] = 32'h11; rf[2] = 32'h22; rf[3] = 32'h33;
        issue(5'd1, 5'd2, 5'd9, 1'b1);
        step();
        check("sc_first_busy", busy_vec, 32'h0000_0200);
        step();
        issue(5'd9, 5'd3, 5'd9, 1'b1);
        wb_cycle(5'd9, 32'h99);
        check("sc_ex_valid", {31'b0, ex_valid}, 32'd1);
        check("sc_rs1_fwd", ex_rs1_data, 32'h99);
        check("sc_rs2", ex_rs2_data, 32'h33);
        check("sc_set_wins", busy_vec, 32'h0000_0200);
        step();

        // Flush while stalled in FETCH
        issue(5'd9, 5'd0, 5'd11, 1'b1);
        step();
        check("fl_stalled", {31'b0, ex_valid}, 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_id_ready", {31'b0, id_ready}, 32'd1);
        check("fl_ex_valid", {31'b0, ex_valid}, 32'd0);
        check("fl_busy", busy_vec, 32'h0);

        // Asynchronous reset while holding in OUT
        ex_ready = 1'b0;
        issue(5'd5, 5'd6, 5'd12, 1'b1);
        step();
        check("ar_pre_ex_valid", {31'b0, ex_valid}, 32'd1);
        check("ar_pre_busy", busy_vec, 32'h0000_1000);
        #2;
        rst = 1'b0;
        #1;
        check("ar_ex_valid", {31'b0, ex_valid}, 32'd0);
        check("ar_busy", busy_vec, 32'h0);
        check("ar_id_ready", {31'b0, id_ready}, 32'd1);
        check("ar_rf_addr", {27'b0, rf_r1_addr}, 32'd0);
        check("ar_ex_rs1", ex_rs1_data, 32'h0);
        step();
        rst = 1'b1;
        ex_ready = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
